// File: rtl/clk_div_sel_pkg.sv
// Shared types and constants for the divided-clock selector.
// State encoding, source indices and the rising-edge helper live here.
package clk_div_sel_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StPark  = 2'd2
    } state_e;

    localparam int unsigned DIV2 = 0;
    localparam int unsigned DIV4 = 1;
    localparam int unsigned DIV8 = 2;

    function automatic logic rise(input logic nxt, input logic cur);
        return nxt & ~cur;
    endfunction

endpackage

// File: rtl/clk_div_sel_if.sv
// Ratio-select request channel: requester drives sel_valid/sel, the selector
// answers with ready, a reject pulse and the active source index.
interface clk_div_sel_if #(
    parameter int unsigned SEL_W = 2
);
    logic             sel_valid;
    logic [SEL_W-1:0] sel;
    logic             sel_ready;
    logic             sel_err;
    logic [SEL_W-1:0] cur_sel;

    modport master (
        output sel_valid,
        output sel,
        input  sel_ready,
        input  sel_err,
        input  cur_sel
    );

    modport slave (
        input  sel_valid,
        input  sel,
        output sel_ready,
        output sel_err,
        output cur_sel
    );
endinterface

// File: rtl/clk_div_edge_cnt.sv
// Tick generator and wrapping tick counter for the selected divided level.
// Looks at the next and current div_out so the tick lands with the 0->1 edge.
module clk_div_edge_cnt
    import clk_div_sel_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_next,
    input  logic             div_cur,
    output logic             tick,
    output logic [CNT_W-1:0] tick_cnt
);

    logic             rise_w;
    logic             tick_q;
    logic [CNT_W-1:0] cnt_q;

    assign rise_w = rise(div_next, div_cur);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tick_q <= rise_w;
            cnt_q  <= cnt_q + CNT_W'(rise_w);
        end
    end

    assign tick     = tick_q;
    assign tick_cnt = cnt_q;

endmodule

// File: rtl/clk_div_sel.sv
// Run-time selector over the /2,/4,/8 divider outputs with a glitch-free switch:
// drain the old high, park low for MIN_LOW cycles, then hand over on a low phase.
module clk_div_sel
    import clk_div_sel_pkg::*;
#(
    parameter int unsigned NSRC    = 3,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned MIN_LOW = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NSRC-1:0]     clk_div,
    clk_div_sel_if.slave        req,
    output logic                div_out,
    output logic                tick,
    output logic [CNT_W-1:0]    tick_cnt
);

    localparam int unsigned    LOW_W  = (MIN_LOW < 2) ? 1 : $clog2(MIN_LOW + 1);
    localparam logic [SEL_W:0] NSRC_L = (SEL_W + 1)'(NSRC);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             div_q, div_d;

    logic             cur_bit;
    logic             pend_bit;
    logic             sel_ok;
    logic             accept;

    // Compare-based mux keeps index widths independent of NSRC.
    always_comb begin
        cur_bit  = 1'b0;
        pend_bit = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (cur_sel_q == SEL_W'(i)) cur_bit = clk_div[i];
            if (pend_q == SEL_W'(i))    pend_bit = clk_div[i];
        end
    end

    assign sel_ok = ({1'b0, req.sel} < NSRC_L);
    assign accept = req.sel_valid & ready_q;

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        pend_d    = pend_q;
        low_cnt_d = low_cnt_q;
        ready_d   = ready_q;
        err_d     = 1'b0;
        div_d     = div_q;

        case (state_q)
            StRun: begin
                div_d = cur_bit;
                if (accept) begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else if (req.sel != cur_sel_q) begin
                        pend_d  = req.sel;
                        ready_d = 1'b0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Let the old high run out before parking.
                div_d = cur_bit;
                if (!cur_bit) begin
                    low_cnt_d = LOW_W'(1);
                    state_d   = StPark;
                end
            end
            StPark: begin
                div_d = 1'b0;
                if (low_cnt_q < LOW_W'(MIN_LOW)) begin
                    low_cnt_d = low_cnt_q + LOW_W'(1);
                end
                // Hand over only in a low phase of the new source.
                if ((low_cnt_q >= LOW_W'(MIN_LOW)) && !pend_bit) begin
                    cur_sel_d = pend_q;
                    ready_d   = 1'b1;
                    state_d   = StRun;
                end
            end
            default: begin
                div_d   = 1'b0;
                ready_d = 1'b1;
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StRun;
            cur_sel_q <= SEL_W'(DIV2);
            pend_q    <= SEL_W'(DIV2);
            low_cnt_q <= '0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            div_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            pend_q    <= pend_d;
            low_cnt_q <= low_cnt_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            div_q     <= div_d;
        end
    end

    clk_div_edge_cnt #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk      (clk),
        .reset    (reset),
        .div_next (div_d),
        .div_cur  (div_q),
        .tick     (tick),
        .tick_cnt (tick_cnt)
    );

    assign div_out       = div_q;
    assign req.sel_ready = ready_q;
    assign req.sel_err   = err_q;
    assign req.cur_sel   = cur_sel_q;

endmodule

// File: tb/tb_clk_div_sel.sv
// Directed bench for clk_div_sel: a free-running divider counter feeds two
// instances (8-bit and 3-bit tick counters) that see identical stimulus.
module tb_clk_div_sel;
    import clk_div_sel_pkg::*;

    localparam int unsigned NSRC  = 3;
    localparam int unsigned SEL_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      dcnt;
    logic            hold;
    logic [NSRC-1:0] clk_div;

    logic            div_out, tick;
    logic [7:0]      tick_cnt;
    logic            div_out_w3, tick_w3;
    logic [2:0]      tick_cnt_w3;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_sel_if #(.SEL_W(SEL_W)) req_if ();
    clk_div_sel_if #(.SEL_W(SEL_W)) req_w3_if ();

    always #5 clk = ~clk;

    assign clk_div = hold ? '0 : dcnt[2:0];

    clk_div_sel #(
        .NSRC(NSRC), .SEL_W(SEL_W), .MIN_LOW(2), .CNT_W(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_div  (clk_div),
        .req      (req_if.slave),
        .div_out  (div_out),
        .tick     (tick),
        .tick_cnt (tick_cnt)
    );

    clk_div_sel #(
        .NSRC(NSRC), .SEL_W(SEL_W), .MIN_LOW(2), .CNT_W(3)
    ) dut_w3 (
        .clk      (clk),
        .reset    (reset),
        .clk_div  (clk_div),
        .req      (req_w3_if.slave),
        .div_out  (div_out_w3),
        .tick     (tick_w3),
        .tick_cnt (tick_cnt_w3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: outputs are read 1 time unit after the edge; the divider
    // advances at the same point, so the next edge samples the new value.
    task automatic step();
        @(posedge clk);
        #1;
        dcnt = dcnt + 8'd1;
    endtask

    task automatic set_req(input logic v, input logic [SEL_W-1:0] s);
        req_if.sel_valid    = v;
        req_if.sel          = s;
        req_w3_if.sel_valid = v;
        req_w3_if.sel       = s;
    endtask

    logic exp_div, prev_div;

    initial begin
        reset = 1'b1;
        hold  = 1'b0;
        dcnt  = 8'd5;
        set_req(1'b0, '0);

        // T1: reset with the divider toggling.
        repeat (3) step();
        check("t1_div_out", div_out, 0);
        check("t1_tick", tick, 0);
        check("t1_tick_cnt", tick_cnt, 0);
        check("t1_ready", req_if.sel_ready, 1);
        check("t1_cur_sel", req_if.cur_sel, 0);
        check("t1_err", req_if.sel_err, 0);
        dcnt  = 8'd0;
        reset = 1'b0;

        // T2: /2 for 16 clocks, div_out is clk_div[0] one clock late.
        for (int j = 1; j <= 16; j++) begin
            step();
            check("t2_div_out", div_out, 32'((j - 1) & 1));
            check("t2_tick", tick, (j % 2 == 0) ? 1 : 0);
        end
        check("t2_tick_cnt", tick_cnt, 8);
        check("t2_tick_cnt_w3", tick_cnt_w3, 0);

        // T3: switch 0->2 issued while clk_div[0] is high.
        step();
        check("t3_pre_div", div_out, 0);
        set_req(1'b1, SEL_W'(DIV8));
        step();
        set_req(1'b0, '0);
        check("t3_acc_ready", req_if.sel_ready, 0);
        check("t3_old_high", div_out, 1);
        check("t3_old_tick", tick, 1);
        check("t3_acc_cur", req_if.cur_sel, 0);
        for (int k = 0; k < 7; k++) begin
            step();
            check("t3_park_div", div_out, 0);
            check("t3_park_tick", tick, 0);
            check("t3_park_ready", req_if.sel_ready, (k == 6) ? 1 : 0);
        end
        check("t3_cur_sel", req_if.cur_sel, 2);
        prev_div = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_div = 1'(((25 + k) >> 2) & 1);
            check("t3_div8_out", div_out, exp_div);
            check("t3_div8_tick", tick, exp_div & ~prev_div);
            prev_div = exp_div;
        end
        check("t3_tick_cnt", tick_cnt, 11);
        check("t3_tick_cnt_w3", tick_cnt_w3, 3);

        // T4: invalid index, then a same-index no-op.
        set_req(1'b1, 2'd3);
        step();
        set_req(1'b0, '0);
        check("t4_err", req_if.sel_err, 1);
        check("t4_cur_sel", req_if.cur_sel, 2);
        check("t4_ready", req_if.sel_ready, 1);
        check("t4_div_out", div_out, 1);
        step();
        check("t4_err_clear", req_if.sel_err, 0);
        check("t4_div_hold", div_out, 1);
        set_req(1'b1, SEL_W'(DIV8));
        step();
        set_req(1'b0, '0);
        check("t4_noop_ready", req_if.sel_ready, 1);
        check("t4_noop_err", req_if.sel_err, 0);
        check("t4_noop_cur", req_if.cur_sel, 2);

        // T5: reach /4, start 1->2, reset while parked.
        set_req(1'b1, SEL_W'(DIV4));
        step();
        set_req(1'b0, '0);
        check("t5_busy", req_if.sel_ready, 0);
        repeat (4) step();
        check("t5_cur_sel_1", req_if.cur_sel, 1);
        check("t5_ready_1", req_if.sel_ready, 1);
        set_req(1'b1, SEL_W'(DIV8));
        step();
        set_req(1'b0, '0);
        repeat (3) step();
        check("t5_park_ready", req_if.sel_ready, 0);
        check("t5_park_div", div_out, 0);
        reset = 1'b1;
        step();
        check("t5_rst_cur", req_if.cur_sel, 0);
        check("t5_rst_ready", req_if.sel_ready, 1);
        check("t5_rst_div", div_out, 0);
        check("t5_rst_tick", tick, 0);
        check("t5_rst_cnt", tick_cnt, 0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("t5_post_cur", req_if.cur_sel, 0);
            check("t5_post_ready", req_if.sel_ready, 1);
            check("t5_post_div", div_out, 32'((50 + k) & 1));
        end
        check("t5_post_cnt", tick_cnt, 6);

        // T6: 9 ticks wrap the 3-bit counter, then a request while busy.
        reset = 1'b1;
        step();
        dcnt  = 8'd0;
        reset = 1'b0;
        repeat (18) step();
        check("t6_cnt", tick_cnt, 9);
        check("t6_cnt_w3_wrap", tick_cnt_w3, 1);
        set_req(1'b1, SEL_W'(DIV4));
        step();
        set_req(1'b1, SEL_W'(DIV8));
        check("t6_busy_ready", req_if.sel_ready, 0);
        step();
        set_req(1'b0, '0);
        check("t6_busy_ignored_ready", req_if.sel_ready, 0);
        check("t6_busy_err", req_if.sel_err, 0);
        check("t6_drain_high", div_out, 1);
        repeat (5) step();
        check("t6_cur_sel", req_if.cur_sel, 1);
        check("t6_ready", req_if.sel_ready, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t6_no_stale", req_if.cur_sel, 1);
        end

        // Divider held low: no level, no ticks.
        hold = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("hold_div", div_out, 0);
            check("hold_tick", tick, 0);
        end
        check("hold_cnt", tick_cnt, 11);
        check("hold_cnt_w3", tick_cnt_w3, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
